// File: rtl/axi4_lite_queued_manager_if.sv
// AXI4-Lite bus bundle shared by the queued manager and its subordinate.
// The manager modport drives the address/data channels; the subordinate modport answers them.
interface axi4_lite #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport manager (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport subordinate (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_queued_manager.sv
// AXI4-Lite manager fed by an in-order request FIFO; one bus transaction in flight,
// with per-transaction timeout and xRESP fault reporting on a valid/ready response port.
module axi4_lite_queued_manager #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [WIDTH/8-1:0]    req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_fault,
  output logic                  resp_timeout,
  output logic                  busy,
  axi4_lite.manager             axi_m
);
  localparam int STRB_W   = WIDTH / 8;
  localparam int ENTRY_W  = 1 + ADDR_WIDTH + WIDTH + STRB_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_AW_W, WR_RESP, RESP} state_t;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg, count_next;
  logic               req_ready_reg;
  logic               push, pop;

  logic [ENTRY_W-1:0]    head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WIDTH-1:0]      head_wdata;
  logic [STRB_W-1:0]     head_wstrb;

  state_t                state_reg;
  logic [CNT_W-1:0]      tmo_cnt_reg;
  logic                  aw_done_reg, w_done_reg;
  logic                  arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]      wdata_reg;
  logic [STRB_W-1:0]     wstrb_reg;
  logic                  resp_valid_reg, resp_fault_reg, resp_timeout_reg;
  logic [WIDTH-1:0]      resp_rdata_reg;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, in_axi, expire;

  assign push       = req_valid && req_ready_reg;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  assign count_next = count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

  assign head       = fifo_mem[rd_ptr_reg];
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[ENTRY_W-2 -: ADDR_WIDTH];
  assign head_wdata = head[WIDTH+STRB_W-1 -: WIDTH];
  assign head_wstrb = head[STRB_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_write, req_addr, req_wdata, req_wstrb};
    end
  end

  // Ready is registered from the next-cycle full flag, so a full FIFO never
  // accepts even when the engine pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      req_ready_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      req_ready_reg <= (count_next != (PTR_W + 1)'(DEPTH));
    end
  end

  assign ar_hs  = arvalid_reg && axi_m.arready;
  assign r_hs   = rready_reg  && axi_m.rvalid;
  assign aw_hs  = awvalid_reg && axi_m.awready;
  assign w_hs   = wvalid_reg  && axi_m.wready;
  assign b_hs   = bready_reg  && axi_m.bvalid;
  assign in_axi = (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                  (state_reg == WR_AW_W) || (state_reg == WR_RESP);
  // A completing R/B handshake on the expiry edge takes priority over the timeout.
  assign expire = (TIMEOUT != 0) && in_axi && (tmo_cnt_reg == CNT_W'(TMO_LAST)) && !r_hs && !b_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      tmo_cnt_reg      <= '0;
      aw_done_reg      <= 1'b0;
      w_done_reg       <= 1'b0;
      arvalid_reg      <= 1'b0;
      rready_reg       <= 1'b0;
      awvalid_reg      <= 1'b0;
      wvalid_reg       <= 1'b0;
      bready_reg       <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      wstrb_reg        <= '0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      resp_fault_reg   <= 1'b0;
      resp_timeout_reg <= 1'b0;
    end else begin
      if (in_axi) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            tmo_cnt_reg <= '0;
            addr_reg    <= head_addr;
            wdata_reg   <= head_wdata;
            wstrb_reg   <= head_wstrb;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            if (head_write) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_AW_W;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready_reg       <= 1'b0;
            resp_rdata_reg   <= axi_m.rdata;
            resp_fault_reg   <= (axi_m.rresp != RESP_OKAY);
            resp_timeout_reg <= 1'b0;
            resp_valid_reg   <= 1'b1;
            state_reg        <= RESP;
          end
        end
        WR_AW_W: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_reg       <= 1'b0;
            resp_rdata_reg   <= '0;
            resp_fault_reg   <= (axi_m.bresp != RESP_OKAY);
            resp_timeout_reg <= 1'b0;
            resp_valid_reg   <= 1'b1;
            state_reg        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (expire) begin
        arvalid_reg      <= 1'b0;
        rready_reg       <= 1'b0;
        awvalid_reg      <= 1'b0;
        wvalid_reg       <= 1'b0;
        bready_reg       <= 1'b0;
        resp_valid_reg   <= 1'b1;
        resp_rdata_reg   <= '0;
        resp_fault_reg   <= 1'b1;
        resp_timeout_reg <= 1'b1;
        state_reg        <= RESP;
      end
    end
  end

  assign req_ready     = req_ready_reg;
  assign resp_valid    = resp_valid_reg;
  assign resp_rdata    = resp_rdata_reg;
  assign resp_fault    = resp_fault_reg;
  assign resp_timeout  = resp_timeout_reg;
  assign busy          = (count_reg != '0) || (state_reg != IDLE);

  assign axi_m.araddr  = addr_reg;
  assign axi_m.arprot  = 3'b000;
  assign axi_m.arvalid = arvalid_reg;
  assign axi_m.rready  = rready_reg;
  assign axi_m.awaddr  = addr_reg;
  assign axi_m.awprot  = 3'b000;
  assign axi_m.awvalid = awvalid_reg;
  assign axi_m.wdata   = wdata_reg;
  assign axi_m.wstrb   = wstrb_reg;
  assign axi_m.wvalid  = wvalid_reg;
  assign axi_m.bready  = bready_reg;
endmodule
